seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Multiplexed 7-segment display driver and the consumer of the divider's display-refresh strobe. It lights one digit per strobe and cycles through NUM_DIGITS digits. Values arrive through a load handshake, are double-buffered, and are applied only at frame boundaries so a digit never tears mid-scan. The block sits between the divider and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
AN_ACTIVE_LOW, 1, 1 = anodes driven low to enable
SEG_ACTIVE_LOW, 1, 1 = segments and dp driven low to light

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
scan_tick  input  1  one-clk strobe from divider; advances scan; used as enable, never as a clock
load  input  1  one-clk strobe; capture value/dp_in into shadow
value  input  4*NUM_DIGITS  hex nibbles; nibble i ([4i+3:4i]) -> digit i; digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
blank  input  1  level; forces display dark
an  output  NUM_DIGITS  anode enables, one-hot when lit
seg  output  7  segments, seg[0]=a .. seg[6]=g
dp  output  1  decimal point of current digit
frame_done  output  1  one-clk pulse when scan leaves last digit
load_ack  output  1  one-clk pulse when shadow committed to active

Behaviour:
- State: shadow value/dp, active value/dp, pend flag, digit index idx (clog2 width), running flag. All outputs registered.
- Reset (async assert, sync release): idx=0, running=0, pend=0, shadow=active=0. an all inactive, seg all off, dp off, frame_done=0, load_ack=0.
- load: shadow<=value/dp_in, pend<=1. Repeated loads before commit: last wins, no error.
- scan_tick while running=0: running<=1, idx stays 0, digit 0 driven. Start-of-frame commit applies. No frame_done.
- scan_tick while running, idx<NUM_DIGITS-1: idx<=idx+1.
- scan_tick while running, idx==NUM_DIGITS-1: idx<=0, frame_done pulses, start-of-frame commit applies.
- Start-of-frame commit: if pend or a coincident load, active<=data. Coincident load data takes priority over shadow. Then pend<=0 and load_ack pulses on the same edge. Otherwise active is unchanged and there is no load_ack.
- Load on a non-boundary tick: captured only; current frame continues from old active.
- Output latency: an/seg/dp reflect the new idx and active on the same edge that updates idx, i.e. visible the cycle after scan_tick.
- No scan_tick: outputs hold indefinitely.
- Decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Invert when SEG_ACTIVE_LOW.
- blank: sampled every clk. While high, next edge forces an inactive, seg/dp off. idx, commit and pulses proceed normally. On release, the next edge drives the current idx.
- frame_done and load_ack are exactly one clk wide, never back-to-back.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: digit i>0 shows seg off when nibbles i..NUM_DIGITS-1 of active are all zero. Its anode is still enabled and its dp is still shown. Digit 0 is never blanked.
- Undefined: all digits always decoded.

Test Plan:
1. rst_n=0 mid-frame -> immediately an=1111, seg=7F, dp=1, frame_done=load_ack=0; after release, no change until scan_tick.
2. load value=16'h12AF, dp_in=0, then 5 scan_ticks -> tick1: load_ack, an=1110 seg=0E; tick2: an=1101 seg=08; tick3: an=1011 seg=24; tick4: an=0111 seg=79; tick5: frame_done, an=1110 seg=0E, no load_ack.
3. Active 16'h1234, at idx=1 load 16'h5678 -> next ticks show 2 (seg=24), 1 (seg=79); wrap tick gives frame_done+load_ack, digit0 seg=00 ('8').
4. load 16'h1111 then 16'h2222 mid-frame; load 16'h3333 coincident with wrap tick -> digit0 shows 3 (seg=30), single load_ack.
5. blank=1 for 2 ticks at idx=0 -> an=1111 next clk, frame_done still fires on schedule; blank=0 -> an=1011 (idx=2) next clk.
6. LEADING_ZERO_BLANK_EN, value=16'h0040 -> digit3/digit2 seg=7F with anode on, digit1 seg=19, digit0 seg=40; value=0 -> only digit0 lit ('0').

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundle of the strobes, load data and display pins between the scan controller
// and the 7-segment driver.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      scan_tick;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_done;
    logic                      load_ack;

    modport master (
        output scan_tick, load, value, dp_in, blank,
        input  an, seg, dp, frame_done, load_ack
    );

    modport slave (
        input  scan_tick, load, value, dp_in, blank,
        output an, seg, dp, frame_done, load_ack
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: double-buffered digit values committed at frame
// boundaries. Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic                      running_reg, running_next;
    logic                      pend_reg, pend_next;
    logic [4*NUM_DIGITS-1:0]   shadow_value_reg, shadow_value_next;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg, shadow_dp_next;
    logic [4*NUM_DIGITS-1:0]   active_value_reg, active_value_next;
    logic [NUM_DIGITS-1:0]     active_dp_reg, active_dp_next;
    logic                      frame_done_reg, frame_done_next;
    logic                      load_ack_reg, load_ack_next;
    logic [NUM_DIGITS-1:0]     an_reg, an_next;
    logic [6:0]                seg_reg, seg_next;
    logic                      dp_reg, dp_next;

    logic                      boundary;
    logic                      commit;
    logic [3:0]                nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     an_hot;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // A frame starts on the first tick after reset and on every wrap tick.
    assign boundary = bus.scan_tick && (!running_reg || (idx_reg == LAST_IDX));
    assign commit   = boundary && (pend_reg || bus.load);

    always_comb begin
        idx_next          = idx_reg;
        running_next      = running_reg;
        pend_next         = pend_reg;
        shadow_value_next = shadow_value_reg;
        shadow_dp_next    = shadow_dp_reg;
        active_value_next = active_value_reg;
        active_dp_next    = active_dp_reg;
        frame_done_next   = 1'b0;
        load_ack_next     = commit;

        if (bus.load) begin
            shadow_value_next = bus.value;
            shadow_dp_next    = bus.dp_in;
            pend_next         = 1'b1;
        end

        if (bus.scan_tick) begin
            running_next = 1'b1;
            if (!running_reg || idx_reg == LAST_IDX) begin
                idx_next        = '0;
                frame_done_next = running_reg;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end

        // A load landing on the boundary tick beats the older shadow contents.
        if (commit) begin
            active_value_next = bus.load ? bus.value : shadow_value_reg;
            active_dp_next    = bus.load ? bus.dp_in : shadow_dp_reg;
            pend_next         = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]    = active_value_next[4*gi +: 4];
            assign an_hot[gi] = (idx_next == IDX_W'(gi));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
            assign lead_zero[gi] = (active_value_next[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate
`endif

    // Outputs are built from next-state so they track idx/active on the same edge.
    always_comb begin
        logic       dark;
        logic [6:0] seg_on;
        dark   = bus.blank || !running_next;
        seg_on = decode(nib[idx_next]);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_next != '0 && lead_zero[idx_next]) begin
            seg_on = '0;
        end
`endif
        an_next  = dark ? '0 : an_hot;
        seg_next = dark ? '0 : seg_on;
        dp_next  = dark ? 1'b0 : active_dp_next[idx_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg          <= '0;
            running_reg      <= 1'b0;
            pend_reg         <= 1'b0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            active_value_reg <= '0;
            active_dp_reg    <= '0;
            frame_done_reg   <= 1'b0;
            load_ack_reg     <= 1'b0;
            an_reg           <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_reg          <= {7{SEG_ACTIVE_LOW}};
            dp_reg           <= SEG_ACTIVE_LOW;
        end else begin
            idx_reg          <= idx_next;
            running_reg      <= running_next;
            pend_reg         <= pend_next;
            shadow_value_reg <= shadow_value_next;
            shadow_dp_reg    <= shadow_dp_next;
            active_value_reg <= active_value_next;
            active_dp_reg    <= active_dp_next;
            frame_done_reg   <= frame_done_next;
            load_ack_reg     <= load_ack_next;
            an_reg           <= an_next ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_reg          <= seg_next ^ {7{SEG_ACTIVE_LOW}};
            dp_reg           <= dp_next ^ SEG_ACTIVE_LOW;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.load_ack   = load_ack_reg;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, active-low pins.
// Observed word is {an[3:0], seg[6:0], dp, frame_done, load_ack}.
module tb_seg7_scan_driver;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seg7_scan_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .AN_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {bus.an, bus.seg, bus.dp, bus.frame_done, bus.load_ack};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.scan_tick = 1'b0; bus.load = 1'b0; bus.blank = 1'b0;
        bus.value = '0; bus.dp_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Ticks are spaced by idle cycles, as the divider would do.
    task automatic do_tick(input logic ld, input logic [15:0] v, input logic [3:0] d);
        repeat (2) @(posedge clk);
        #1 bus.scan_tick = 1'b1;
        bus.load = ld;
        if (ld) begin bus.value = v; bus.dp_in = d; end
        @(posedge clk);
        #1 bus.scan_tick = 1'b0;
        bus.load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(posedge clk);
        #1 bus.load = 1'b1; bus.value = v; bus.dp_in = d;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] exp_v;
        do_reset();
        do_load(16'h1234, 4'b0000);
        do_tick(1'b0, '0, '0);
        do_tick(1'b1, 16'h9999, 4'b0000);
        rst_n = 1'b0;
        #1;
        exp_v = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_async: got %h required %h", obs(), exp_v); end
        else $display("reset_async: obs=%h", obs());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_release_hold: got %h required %h", obs(), exp_v); end
        else $display("reset_release_hold: obs=%h", obs());
        // First tick after reset shows digit 0 of a cleared active value, no ack.
        do_tick(1'b0, '0, '0);
        exp_v = {4'hE, 7'h40, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_first_tick: got %h required %h", obs(), exp_v); end
        else $display("reset_first_tick: obs=%h", obs());
    endtask

    task automatic test_scan();
        logic [13:0] exp_t [5];
        exp_t[0] = {4'hE, 7'h0E, 1'b1, 1'b0, 1'b1};
        exp_t[1] = {4'hD, 7'h08, 1'b1, 1'b0, 1'b0};
        exp_t[2] = {4'hB, 7'h24, 1'b0, 1'b0, 1'b0};
        exp_t[3] = {4'h7, 7'h79, 1'b1, 1'b0, 1'b0};
        exp_t[4] = {4'hE, 7'h0E, 1'b1, 1'b1, 1'b0};
        do_reset();
        do_load(16'h12AF, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            do_tick(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_t[i]) begin errors++; $display("FAIL scan_tick%0d: got %h required %h", i + 1, obs(), exp_t[i]); end
            else $display("scan_tick%0d: obs=%h", i + 1, obs());
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== {4'hE, 7'h0E, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL scan_pulse_width: got %h required %h", obs(), {4'hE, 7'h0E, 1'b1, 1'b0, 1'b0}); end
        else $display("scan_pulse_width: obs=%h", obs());
    endtask

    task automatic test_midframe_load();
        logic [13:0] exp_t [4];
        exp_t[0] = {4'hB, 7'h24, 1'b1, 1'b0, 1'b0};
        exp_t[1] = {4'h7, 7'h79, 1'b1, 1'b0, 1'b0};
        exp_t[2] = {4'hE, 7'h00, 1'b1, 1'b1, 1'b1};
        exp_t[3] = {4'hD, 7'h78, 1'b1, 1'b0, 1'b0};
        do_reset();
        do_load(16'h1234, 4'b0000);
        do_tick(1'b0, '0, '0);
        do_tick(1'b0, '0, '0);
        do_load(16'h5678, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_t[i]) begin errors++; $display("FAIL midframe_tick%0d: got %h required %h", i + 1, obs(), exp_t[i]); end
            else $display("midframe_tick%0d: obs=%h", i + 1, obs());
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_t [4];
        exp_t[0] = {4'hB, 7'h02, 1'b1, 1'b0, 1'b0};
        exp_t[1] = {4'h7, 7'h12, 1'b1, 1'b0, 1'b0};
        exp_t[2] = {4'hE, 7'h30, 1'b1, 1'b1, 1'b1};
        exp_t[3] = {4'hD, 7'h30, 1'b1, 1'b0, 1'b0};
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        checks++;
        if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL b2b_no_ack_on_load: got %b required 0", bus.load_ack); end
        else $display("b2b_no_ack_on_load: load_ack=%b", bus.load_ack);
        for (int i = 0; i < 4; i++) begin
            do_tick(i == 2, 16'h3333, 4'b0000);
            checks++;
            if (obs() !== exp_t[i]) begin errors++; $display("FAIL b2b_tick%0d: got %h required %h", i + 1, obs(), exp_t[i]); end
            else $display("b2b_tick%0d: obs=%h", i + 1, obs());
        end
    endtask

    task automatic test_blank();
        logic [13:0] exp_t [4];
        logic [13:0] exp_v;
        exp_t[0] = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        exp_t[1] = {4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
        exp_t[2] = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        exp_t[3] = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        do_tick(1'b0, '0, '0);
        @(posedge clk);
        #1 bus.blank = 1'b1;
        @(posedge clk);
        #1;
        exp_v = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL blank_enter: got %h required %h", obs(), exp_v); end
        else $display("blank_enter: obs=%h", obs());
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_t[i]) begin errors++; $display("FAIL blank_tick%0d: got %h required %h", i + 1, obs(), exp_t[i]); end
            else $display("blank_tick%0d: obs=%h", i + 1, obs());
        end
        bus.blank = 1'b0;
        @(posedge clk);
        #1;
        exp_v = {4'hB, 7'h30, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL blank_release: got %h required %h", obs(), exp_v); end
        else $display("blank_release: obs=%h", obs());
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_s [8];
`ifdef LEADING_ZERO_BLANK_EN
        exp_s[0] = 7'h40; exp_s[1] = 7'h19; exp_s[2] = 7'h7F; exp_s[3] = 7'h7F;
        exp_s[4] = 7'h40; exp_s[5] = 7'h7F; exp_s[6] = 7'h7F; exp_s[7] = 7'h7F;
`else
        exp_s[0] = 7'h40; exp_s[1] = 7'h19; exp_s[2] = 7'h40; exp_s[3] = 7'h40;
        exp_s[4] = 7'h40; exp_s[5] = 7'h40; exp_s[6] = 7'h40; exp_s[7] = 7'h40;
`endif
        do_reset();
        do_load(16'h0040, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << (i % 4));
            do_tick(i == 4, 16'h0000, 4'b0000);
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_s[i]) begin
                errors++;
                $display("FAIL lzb_tick%0d: got an=%h seg=%h required an=%h seg=%h", i + 1, bus.an, bus.seg, exp_an, exp_s[i]);
            end else $display("lzb_tick%0d: an=%h seg=%h", i + 1, bus.an, bus.seg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.scan_tick = 1'b0; bus.load = 1'b0; bus.blank = 1'b0;
        bus.value = '0; bus.dp_in = '0;
        test_reset();
        test_scan();
        test_midframe_load();
        test_back_to_back();
        test_blank();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
